// File: rtl/spi_sclk_generator.sv
// spi_sclk_generator
//   SPI serial-clock generator. Produces a burst of programmable length with
//   runtime CPOL/CPHA, one-cycle sample/shift strobes aligned to the visible
//   SCLK edges, a completed-sample counter and a one-cycle done pulse.
//
//   Optional build macro: SPI_SCLK_CONTINUOUS_EN
//     When defined, a burst request seen in DONE restarts RUN directly, giving
//     back-to-back bursts with no READY cycle in between.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_RESET | just left reset; outputs quiet, moves to READY next cycle
//   ST_READY | idle, o_sclk at cpol; accepts cfg writes and burst requests
//   ST_RUN   | burst in progress; divider running, SCLK toggling
//   ST_DONE  | final edge has been emitted; o_done high for this one cycle

module spi_sclk_generator #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_wr,
    input  logic [DIV_W-1:0] i_half_period,
    input  logic [CNT_W-1:0] i_num_bits,
    input  logic             i_cpol,
    input  logic             i_cpha,
    input  logic             i_start_n,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_sclk,
    output logic             o_sample,
    output logic             o_shift,
    output logic [CNT_W-1:0] o_bit_count,
    output logic             o_done
);

    // Edge counter is one bit wider than the bit count so 2*max_bits fits.
    localparam int EW = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [DIV_W-1:0] half_q;
    logic [CNT_W-1:0] bits_q;
    logic             cpol_q;
    logic             cpha_q;

    logic [DIV_W-1:0] div_cnt_q;
    logic [EW-1:0]    edge_cnt_q;
    logic             sclk_q;
    logic             sample_q;
    logic             shift_q;
    logic [CNT_W-1:0] bit_count_q;
    logic             done_q;

    logic             load_cfg;
    logic             begin_run;
    logic             start_req;
    logic             tick;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] cfg_half_eff;
    logic [EW-1:0]    edge_k;
    logic [EW-1:0]    total_edges;
    logic             last_edge;
    logic             is_sample;
    logic             is_shift;

    assign start_req    = ~i_start_n;

    // A zero half period would stall the divider, so it is stored as 1.
    assign cfg_half_eff = (i_half_period == '0) ? DIV_W'(1) : i_half_period;

    assign half_m1      = half_q - DIV_W'(1);
    assign tick         = (state_q == ST_RUN) && (div_cnt_q == half_m1);

    // edge_k is the 1-based number of the edge about to be emitted on a tick.
    assign edge_k       = edge_cnt_q + EW'(1);
    assign total_edges  = {bits_q, 1'b0};
    assign last_edge    = (edge_k == total_edges);

    // Odd edges are leading, even edges trailing. With cpha=0 the final
    // trailing edge has no bit left to shift out, so it gets no shift strobe.
    assign is_sample    = cpha_q ? ~edge_k[0] : edge_k[0];
    assign is_shift     = cpha_q ?  edge_k[0] : (~edge_k[0] & ~last_edge);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the cfg-load and burst-start qualifiers.
    always_comb begin
        state_d   = state_q;
        load_cfg  = 1'b0;
        begin_run = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                // A cfg write wins over a simultaneous start; the start is dropped.
                if (i_cfg_wr) begin
                    load_cfg = 1'b1;
                end else if (start_req && (bits_q != '0)) begin
                    begin_run = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick && last_edge) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef SPI_SCLK_CONTINUOUS_EN
                if (start_req) begin
                    begin_run = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    state_d = ST_READY;
                end
`else
                state_d = ST_READY;
`endif
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Configuration registers; only written from READY so a burst never sees a change.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            half_q <= DIV_W'(1);
            bits_q <= CNT_W'(8);
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (load_cfg) begin
            half_q <= cfg_half_eff;
            bits_q <= i_num_bits;
            cpol_q <= i_cpol;
            cpha_q <= i_cpha;
        end
    end

    // Half-period divider and edge counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else if (begin_run) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                div_cnt_q  <= '0;
                edge_cnt_q <= edge_k;
            end else begin
                div_cnt_q  <= div_cnt_q + DIV_W'(1);
            end
        end
    end

    // SCLK and its edge strobes, registered together so the strobe marks the
    // cycle in which the new SCLK level is first visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            if (load_cfg) begin
                sclk_q <= i_cpol;
            end else if (tick) begin
                sclk_q   <= ~sclk_q;
                sample_q <= is_sample;
                shift_q  <= is_shift;
            end
        end
    end

    // Completed-sample counter, moving in step with the sample strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bit_count_q <= '0;
        end else if (begin_run) begin
            bit_count_q <= '0;
        end else if (tick && is_sample && (bit_count_q < bits_q)) begin
            bit_count_q <= bit_count_q + CNT_W'(1);
        end
    end

    // Done pulse, high exactly in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_RUN) && (state_d == ST_DONE);
        end
    end

    assign o_ready     = (state_q == ST_READY);
    assign o_busy      = (state_q == ST_RUN);
    assign o_sclk      = sclk_q;
    assign o_sample    = sample_q;
    assign o_shift     = shift_q;
    assign o_bit_count = bit_count_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_spi_sclk_generator.sv
// tb_spi_sclk_generator
//   Directed and randomized bursts checked cycle by cycle against a model that
//   derives the SCLK level, strobes and counts from elapsed time since RUN entry.

module tb_spi_sclk_generator;

    localparam int DIV_W = 8;
    localparam int CNT_W = 6;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_cfg_wr = 1'b0;
    logic [DIV_W-1:0] i_half_period = '0;
    logic [CNT_W-1:0] i_num_bits = '0;
    logic             i_cpol = 1'b0;
    logic             i_cpha = 1'b0;
    logic             i_start_n = 1'b1;
    logic             o_ready;
    logic             o_busy;
    logic             o_sclk;
    logic             o_sample;
    logic             o_shift;
    logic [CNT_W-1:0] o_bit_count;
    logic             o_done;

    int checks = 0;
    int errors = 0;

    spi_sclk_generator #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_cfg_wr      (i_cfg_wr),
        .i_half_period (i_half_period),
        .i_num_bits    (i_num_bits),
        .i_cpol        (i_cpol),
        .i_cpha        (i_cpha),
        .i_start_n     (i_start_n),
        .o_ready       (o_ready),
        .o_busy        (o_busy),
        .o_sclk        (o_sclk),
        .o_sample      (o_sample),
        .o_shift       (o_shift),
        .o_bit_count   (o_bit_count),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first RUN cycle (t=0); returns at the DONE cycle (t=T).
    // A cfg write is attempted mid-burst and must have no effect.
    task automatic check_burst(input int he, input int bits, input bit cpol, input bit cpha);
        int T;
        int ne;
        int k;
        int nsamp;
        int nshift;
        bit on_edge;
        bit exp_s;
        bit exp_sh;
        int exp_cnt;
        T = 2 * bits * he;
        nsamp = 0;
        nshift = 0;
        for (int t = 0; t <= T; t++) begin
            ne = t / he;
            k = ne;
            on_edge = (t > 0) && ((t % he) == 0);
            exp_s = on_edge && (cpha ? (k % 2 == 0) : (k % 2 == 1));
            exp_sh = on_edge && (cpha ? (k % 2 == 1) : ((k % 2 == 0) && (k != 2 * bits)));
            exp_cnt = cpha ? (ne / 2) : ((ne + 1) / 2);
            check("sclk", o_sclk, cpol ^ ne[0]);
            check("sample", o_sample, exp_s);
            check("shift", o_shift, exp_sh);
            check("bit_count", o_bit_count, exp_cnt);
            check("busy", o_busy, (t < T));
            check("done", o_done, (t == T));
            nsamp += o_sample;
            nshift += o_shift;
            if (t == 1) begin
                i_cfg_wr = 1'b1;
                i_half_period = DIV_W'($urandom_range(0, 255));
                i_num_bits = CNT_W'($urandom_range(0, 63));
                i_cpol = ~cpol;
                i_cpha = ~cpha;
            end else begin
                i_cfg_wr = 1'b0;
            end
            if (t < T) step();
        end
        i_cfg_wr = 1'b0;
        check("sample_total", nsamp, bits);
        check("shift_total", nshift, cpha ? bits : bits - 1);
    endtask

    // Configure, request a burst and check it. collide drives start during the
    // cfg write (must be dropped); hold keeps start low through DONE.
    task automatic run_burst(input int half_in, input int bits, input bit cpol, input bit cpha,
                             input bit collide, input bit hold);
        int he;
        he = (half_in == 0) ? 1 : half_in;
        i_cfg_wr = 1'b1;
        i_half_period = DIV_W'(half_in);
        i_num_bits = CNT_W'(bits);
        i_cpol = cpol;
        i_cpha = cpha;
        i_start_n = collide ? 1'b0 : 1'b1;
        step();
        i_cfg_wr = 1'b0;
        i_start_n = 1'b1;
        check("idle_ready", o_ready, 1'b1);
        check("idle_busy", o_busy, 1'b0);
        check("idle_sclk", o_sclk, cpol);
        i_start_n = 1'b0;
        step();
        if (!hold) i_start_n = 1'b1;
        check_burst(he, bits, cpol, cpha);
        step();
        if (hold) begin
`ifdef SPI_SCLK_CONTINUOUS_EN
            check("b2b_ready", o_ready, 1'b0);
`else
            check("gap_ready", o_ready, 1'b1);
            check("gap_busy", o_busy, 1'b0);
            check("gap_done", o_done, 1'b0);
            step();
`endif
            i_start_n = 1'b1;
            check_burst(he, bits, cpol, cpha);
            step();
        end
        check("end_ready", o_ready, 1'b1);
        check("end_done", o_done, 1'b0);
        check("end_sclk", o_sclk, cpol);
    endtask

    initial begin
        // Reset values
        i_rst_n = 1'b0;
        step();
        step();
        check("rst_ready", o_ready, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_sclk", o_sclk, 1'b0);
        check("rst_sample", o_sample, 1'b0);
        check("rst_shift", o_shift, 1'b0);
        check("rst_count", o_bit_count, 0);
        check("rst_done", o_done, 1'b0);
        i_rst_n = 1'b1;
        step();
        check("rst_exit_ready", o_ready, 1'b1);

        // Burst with reset-default cfg (half=1 bits=8 mode 0), no cfg write
        i_start_n = 1'b0;
        step();
        i_start_n = 1'b1;
        check_burst(1, 8, 1'b0, 1'b0);
        step();
        check("dflt_ready", o_ready, 1'b1);

        // Mode 0, half=2, bits=8
        run_burst(2, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        // Mode 3, half=1, bits=4
        run_burst(1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        // half=0 treated as 1, single bit
        run_burst(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        // cfg write and start in the same cycle
        run_burst(3, 5, 1'b1, 1'b0, 1'b1, 1'b0);

        // bits=0: start ignored
        i_cfg_wr = 1'b1;
        i_half_period = 8'd2;
        i_num_bits = '0;
        i_cpol = 1'b0;
        i_cpha = 1'b0;
        step();
        i_cfg_wr = 1'b0;
        i_start_n = 1'b0;
        step();
        step();
        i_start_n = 1'b1;
        check("zero_bits_busy", o_busy, 1'b0);
        check("zero_bits_ready", o_ready, 1'b1);

        // Reset mid-burst at edge 5 of 16
        i_cfg_wr = 1'b1;
        i_half_period = 8'd2;
        i_num_bits = 6'd8;
        step();
        i_cfg_wr = 1'b0;
        i_start_n = 1'b0;
        step();
        i_start_n = 1'b1;
        for (int t = 0; t < 10; t++) step();
        check("pre_rst_sclk", o_sclk, 1'b1);
        check("pre_rst_count", o_bit_count, 3);
        i_rst_n = 1'b0;
        step();
        check("mid_rst_sclk", o_sclk, 1'b0);
        check("mid_rst_count", o_bit_count, 0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_ready", o_ready, 1'b0);
        check("mid_rst_done", o_done, 1'b0);
        step();
        check("mid_rst_done2", o_done, 1'b0);
        i_rst_n = 1'b1;
        step();
        check("post_rst_ready", o_ready, 1'b1);
        check("post_rst_done", o_done, 1'b0);

        // Start held low through DONE
        run_burst(2, 3, 1'b0, 1'b1, 1'b0, 1'b1);
        run_burst(1, 2, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized bursts
        for (int n = 0; n < 24; n++) begin
            run_burst($urandom_range(0, 5), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Maximum bits and divisor
        run_burst(255, 63, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
